micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer.sv | 133 +++++++++++++
 tb/tb_micro_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Micro-coded control sequencer: walks a fixed micro-routine per opcode class
// and reports the micro-state, sequencing mode, register-file select and retirements.
module micro_sequencer #(
    parameter int UPC_W     = 6,
    parameter int CNT_W     = 16,
    parameter bit EN_BRANCH = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [6:0]       opcode,
    input  logic             br_cond,
    output logic [UPC_W-1:0] upc,
    output logic [1:0]       seq,
    output logic [1:0]       rf_sel,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    if (UPC_W < 5) begin : g_upc_w_check
        $error("micro_sequencer: UPC_W must be at least 5");
    end

    typedef enum logic [4:0] {
        S_INIT = 5'd0,
        S_F0   = 5'd1,  S_F1,  S_F2,
        S_A0   = 5'd4,  S_A1,  S_A2,  S_A3,
        S_AI0  = 5'd8,  S_AI1, S_AI2, S_AI3,
        S_LW0  = 5'd12, S_LW1, S_LW2, S_LW3,
        S_SW0  = 5'd16, S_SW1, S_SW2, S_SW3,
        S_JR0  = 5'd20, S_JR1, S_JR2, S_JR3,
        S_BR0  = 5'd24, S_BR1, S_BR2,
        S_TRAP = 5'd27
    } state_t;

    localparam logic [1:0] SEQ_N  = 2'd0;
    localparam logic [1:0] SEQ_D  = 2'd1;
    localparam logic [1:0] SEQ_F  = 2'd2;
    localparam logic [1:0] SEQ_B  = 2'd3;
    localparam logic [1:0] RF_X0  = 2'd0;
    localparam logic [1:0] RF_RD  = 2'd1;
    localparam logic [1:0] RF_RS1 = 2'd2;
    localparam logic [1:0] RF_RS2 = 2'd3;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_JR = 7'b1100111;
    localparam logic [6:0] OP_BR = 7'b1100011;

    state_t state, state_d;
    logic   known;

    // Handshake: stall=1 means the datapath cannot accept this micro-step; the
    // sequencer holds its state (and everything decoded from it) until stall=0.
    // init and trap are bookkeeping states and advance regardless of stall.

    always_comb begin
        seq   = SEQ_N;
        known = 1'b1;
        case (state)
            S_INIT, S_TRAP, S_A3, S_AI3, S_LW3, S_SW3, S_JR3, S_BR2: seq = SEQ_F;
            S_F2:  seq = SEQ_D;
            S_BR1: seq = SEQ_B;
            S_F0, S_F1, S_A0, S_A1, S_A2, S_AI0, S_AI1, S_AI2,
            S_LW0, S_LW1, S_LW2, S_SW0, S_SW1, S_SW2,
            S_JR0, S_JR1, S_JR2, S_BR0: seq = SEQ_N;
            default: known = 1'b0;
        endcase
    end

    always_comb begin
        rf_sel = RF_X0;
        case (state)
            S_A0, S_AI0, S_LW0, S_SW0, S_JR0, S_BR0: rf_sel = RF_RS1;
            S_A1, S_SW1, S_BR1:                      rf_sel = RF_RS2;
            S_A3, S_AI3, S_LW3, S_JR3:               rf_sel = RF_RD;
            default:                                 rf_sel = RF_X0;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            S_INIT, S_TRAP: state_d = S_F0;
            S_F2: begin
                case (opcode)
                    OP_R:    state_d = S_A0;
                    OP_I:    state_d = S_AI0;
                    OP_LD:   state_d = S_LW0;
                    OP_ST:   state_d = S_SW0;
                    OP_JR:   state_d = S_JR0;
                    OP_BR:   state_d = EN_BRANCH ? S_BR0 : S_TRAP;
                    default: state_d = S_TRAP;
                endcase
            end
            S_BR1: state_d = br_cond ? S_BR2 : S_F0;
            default: begin
                if (!known)
                    state_d = S_INIT;
                else if (seq == SEQ_F)
                    state_d = S_F0;
                else
                    state_d = state_t'(state + 5'd1);
            end
        endcase
        if (stall && known && state != S_INIT && state != S_TRAP)
            state_d = state;
    end

    // Retirement: leaving the last step of a routine, or a not-taken branch.
    assign instr_done = !stall &&
                        ((seq == SEQ_F && state != S_INIT && state != S_TRAP) ||
                         (state == S_BR1 && !br_cond));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_INIT;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state   <= state_d;
            illegal <= (state_d == S_TRAP);
            if (instr_done)
                retired <= retired + CNT_W'(1);
        end
    end

    assign upc = UPC_W'(state);

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: two instances (default, and CNT_W=2/EN_BRANCH=0)
// checked every cycle against a routine-level model plus directed literal traces.
module tb_micro_sequencer;
    localparam int UPC_W = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       stall = 1'b0;
    logic       br_cond = 1'b0;
    logic [6:0] opcode = 7'd0;

    logic [UPC_W-1:0] upc1, upc2;
    logic [1:0]       seq1, seq2, rf1, rf2;
    logic             ill1, ill2, done1, done2;
    logic [15:0]      ret1;
    logic [1:0]       ret2;

    micro_sequencer #(.UPC_W(UPC_W), .CNT_W(16), .EN_BRANCH(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .opcode(opcode), .br_cond(br_cond),
        .upc(upc1), .seq(seq1), .rf_sel(rf1), .illegal(ill1), .instr_done(done1),
        .retired(ret1)
    );

    micro_sequencer #(.UPC_W(UPC_W), .CNT_W(2), .EN_BRANCH(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .opcode(opcode), .br_cond(br_cond),
        .upc(upc2), .seq(seq2), .rf_sel(rf2), .illegal(ill2), .instr_done(done2),
        .retired(ret2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Routine-level model: micro-PC as an integer walked through routine tables.
    int m_upc[2]   = '{0, 0};
    int m_ret[2]   = '{0, 0};
    int cnt_mod[2] = '{65536, 4};
    bit en_br[2]   = '{1'b1, 1'b0};

    function automatic bit is_last(input int u);
        return u == 7 || u == 11 || u == 15 || u == 19 || u == 23 || u == 26;
    endfunction

    function automatic int routine_entry(input logic [6:0] op, input bit en);
        case (op)
            7'b0110011: return 4;
            7'b0010011: return 8;
            7'b0000011: return 12;
            7'b0100011: return 16;
            7'b1100111: return 20;
            7'b1100011: return en ? 24 : 27;
            default:    return 27;
        endcase
    endfunction

    function automatic bit exp_done(input int u);
        return !stall && (is_last(u) || (u == 25 && !br_cond));
    endfunction

    function automatic int exp_next(input int u, input bit en);
        if (u == 0 || u == 27) return 1;
        if (u > 27) return 0;
        if (stall) return u;
        if (u == 3) return routine_entry(opcode, en);
        if (u == 25) return br_cond ? 26 : 1;
        if (is_last(u)) return 1;
        return u + 1;
    endfunction

    function automatic int exp_seq(input int u);
        if (u == 0 || u == 27 || is_last(u)) return 2;
        if (u == 3) return 1;
        if (u == 25) return 3;
        return 0;
    endfunction

    function automatic int exp_rf(input int u);
        int step;
        if (u < 4 || u > 26) return 0;
        step = (u < 24) ? (u - 4) % 4 : u - 24;
        if (step == 0) return 2;
        if (step == 1 && (u == 5 || u == 17 || u == 25)) return 3;
        if (step == 3 && u != 19) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_upc[i] = 0;
                m_ret[i] = 0;
            end else begin
                if (exp_done(m_upc[i])) m_ret[i] = (m_ret[i] + 1) % cnt_mod[i];
                m_upc[i] = exp_next(m_upc[i], en_br[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_upc_d1",  int'(upc1),  m_upc[0]);
            check("cmp_seq_d1",  int'(seq1),  exp_seq(m_upc[0]));
            check("cmp_rf_d1",   int'(rf1),   exp_rf(m_upc[0]));
            check("cmp_ill_d1",  int'(ill1),  int'(m_upc[0] == 27));
            check("cmp_done_d1", int'(done1), int'(exp_done(m_upc[0])));
            check("cmp_ret_d1",  int'(ret1),  m_ret[0]);
            check("cmp_upc_d2",  int'(upc2),  m_upc[1]);
            check("cmp_seq_d2",  int'(seq2),  exp_seq(m_upc[1]));
            check("cmp_rf_d2",   int'(rf2),   exp_rf(m_upc[1]));
            check("cmp_ill_d2",  int'(ill2),  int'(m_upc[1] == 27));
            check("cmp_done_d2", int'(done2), int'(exp_done(m_upc[1])));
            check("cmp_ret_d2",  int'(ret2),  m_ret[1]);
        end
    end

    // Directed traces: expected upc of dut1 per cycle, with the stall for that cycle.
    logic [UPC_W-1:0] exp_q[$];
    bit               stl_q[$];

    task automatic push(input int v, input bit s);
        exp_q.push_back(UPC_W'(v));
        stl_q.push_back(s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            stall = stl_q[i];
            check(name, int'(upc1), int'(exp_q[i]));
            tick();
        end
        stall = 1'b0;
        exp_q.delete();
        stl_q.delete();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_upc", int'(upc1), 0);
        check("rst_seq", int'(seq1), 2);
        check("rst_rf", int'(rf1), 0);
        check("rst_ill", int'(ill1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_ret", int'(ret1), 0);
        tick();

        // R-type straight after reset release.
        opcode = 7'b0110011;
        rst_n  = 1'b1;
        for (int v = 0; v <= 7; v++) push(v, 1'b0);
        run_seq("rtype_trace");
        check("rtype_ret1", int'(ret1), 1);
        check("rtype_ret2", int'(ret2), 1);

        // Illegal opcode; trap advances even under stall.
        opcode = 7'b0000000;
        push(1, 0); push(2, 0); push(3, 0);
        run_seq("illegal_trace");
        check("trap_upc", int'(upc1), 27);
        check("trap_ill", int'(ill1), 1);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        check("trap_exit_upc", int'(upc1), 1);
        check("trap_exit_ill", int'(ill1), 0);
        check("trap_ret", int'(ret1), 1);

        // Branch not taken; the EN_BRANCH=0 instance traps instead.
        opcode  = 7'b1100011;
        br_cond = 1'b0;
        push(1, 0); push(2, 0); push(3, 0);
        run_seq("br_nt_fetch");
        check("br_nt_upc", int'(upc1), 24);
        check("br_disabled_upc", int'(upc2), 27);
        push(24, 0); push(25, 0);
        run_seq("br_nt_trace");
        check("br_nt_back", int'(upc1), 1);
        check("br_nt_ret", int'(ret1), 2);

        // Branch taken.
        br_cond = 1'b1;
        push(1, 0); push(2, 0); push(3, 0); push(24, 0); push(25, 0); push(26, 0);
        run_seq("br_t_trace");
        br_cond = 1'b0;
        check("br_t_ret", int'(ret1), 3);

        // Load with a 3-cycle stall at lw1; opcode changes after dispatch are ignored.
        opcode = 7'b0000011;
        push(1, 0); push(2, 0); push(3, 0);
        run_seq("lw_fetch");
        opcode = 7'b0000000;
        push(12, 0); push(13, 1); push(13, 1); push(13, 1); push(13, 0); push(14, 0); push(15, 0);
        run_seq("lw_stall_trace");
        check("lw_back", int'(upc1), 1);
        check("lw_ret", int'(ret1), 4);

        // Store aborted by an asynchronous reset at sw1.
        opcode = 7'b0100011;
        push(1, 0); push(2, 0); push(3, 0); push(16, 0);
        run_seq("sw_trace");
        check("sw1_upc", int'(upc1), 17);
        check("sw1_rf", int'(rf1), 3);
        #3 rst_n = 1'b0;
        #1;
        check("arst_upc1", int'(upc1), 0);
        check("arst_ret1", int'(ret1), 0);
        check("arst_upc2", int'(upc2), 0);
        check("arst_ret2", int'(ret2), 0);
        check("arst_seq1", int'(seq1), 2);
        tick();
        check("arst_hold", int'(upc1), 0);

        // Release with stall=1: init still advances, f0 then holds.
        opcode = 7'b0010011;
        rst_n  = 1'b1;
        push(0, 1); push(1, 1); push(1, 0);
        push(2, 0); push(3, 0); push(8, 0); push(9, 0); push(10, 0); push(11, 0);
        run_seq("ai_first_trace");
        check("ai_ret1_1", int'(ret1), 1);
        check("ai_ret2_1", int'(ret2), 1);

        // Back-to-back immediates wrap the 2-bit counter.
        for (int k = 2; k <= 4; k++) begin
            push(1, 0); push(2, 0); push(3, 0); push(8, 0); push(9, 0); push(10, 0); push(11, 0);
            run_seq("ai_trace");
            check("ai_ret1", int'(ret1), k);
            check("ai_ret2_wrap", int'(ret2), k % 4);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
